// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder: slice width, FSM states
// and the sizing rule for the nibble index register.
package adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index register width: enough bits to count NIBBLES positions, never zero.
  function automatic int idx_w(input int nibbles);
    return (nibbles <= 1) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/nibble_add.sv
// Purely combinational 4-bit ripple-carry slice reused every cycle by the
// serial adder.
module nibble_add
  import adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  logic [NIBBLE_W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign co = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-word adder that walks one 4-bit slice across the operands LSB-first,
// one nibble per cycle, carrying between cycles in a register. Results are
// registered and announced with a one-cycle done pulse.
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NIBBLE_W*NIBBLES-1:0]   a,
  input  logic [NIBBLE_W*NIBBLES-1:0]   b,
  input  logic                          c_in,
  output logic                          busy,
  output logic                          done,
  output logic [NIBBLE_W*NIBBLES-1:0]   sum,
  output logic                          c_out,
  output logic                          overflow
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = idx_w(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  state_t          state_q;
  state_t          state_d;

  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [W-1:0]    work;
  logic [W-1:0]    work_next;
  logic            carry;
  logic [IW-1:0]   idx;

  logic [NIBBLE_W-1:0] slice_a;
  logic [NIBBLE_W-1:0] slice_b;
  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_co;
  logic                last_nibble;

  // Nibble selection straight off the index; the low two zero bits scale
  // idx by the slice width so no shifter is built.
  assign slice_a     = a_reg[{idx, 2'b00} +: NIBBLE_W];
  assign slice_b     = b_reg[{idx, 2'b00} +: NIBBLE_W];
  assign last_nibble = (idx == LAST);

  nibble_add u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  // Working sum with the current slice result merged into its nibble slot.
  always_comb begin
    work_next = work;
    work_next[{idx, 2'b00} +: NIBBLE_W] = slice_s;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state: start only matters in IDLE; DONE lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_nibble) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, per-nibble accumulation and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      work     <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            carry <= c_in;
            work  <= '0;
            idx   <= '0;
          end
        end
        RUN: begin
          work  <= work_next;
          carry <= slice_co;
          if (last_nibble) begin
            sum      <= work_next;
            c_out    <= slice_co;
            // Carry into the MSB equals a^b^s at that bit; XOR with carry out.
            overflow <= a_reg[W-1] ^ b_reg[W-1] ^ work_next[W-1] ^ slice_co;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule
